// File: rtl/aud_pkg.sv
// Shared definitions for the audio playback DSP: default widths and FSM state encodings.
package aud_pkg;

  localparam int AUD_DATA_W  = 16;
  localparam int AUD_ADDR_W  = 20;
  localparam int AUD_SPEED_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LRCK = 3'd1,
    ST_FETCH0    = 3'd2,
    ST_FETCH1    = 3'd3,
    ST_CALC      = 3'd4,
    ST_PAUSE     = 3'd5
  } state_t;

endpackage

// File: rtl/aud_div_seq.sv
// Sequential signed restoring divider: signed numerator over an unsigned non-zero
// divisor, quotient truncated toward zero, one quotient bit per clock.
module aud_div_seq #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 4,
  parameter int QUO_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [NUM_W-1:0] num,
  input  logic        [DEN_W-1:0] den,
  output logic                    busy,
  output logic                    done,
  output logic signed [QUO_W-1:0] quo
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q, den_q, rem_in, den_in, rem_n;
  logic [NUM_W-1:0] acc_q, acc_in, acc_n, mag;
  logic [DEN_W:0]   rem_sh;
  logic [CW-1:0]    cnt_q;
  logic             neg_q, ge;
  logic [QUO_W-1:0] quo_t;

  // The start cycle already performs the first iteration, saving a clock.
  always_comb begin
    mag    = num[NUM_W-1] ? -num : num;
    rem_in = start ? '0 : rem_q;
    acc_in = start ? mag : acc_q;
    den_in = start ? den : den_q;
    rem_sh = {rem_in, acc_in[NUM_W-1]};
    ge     = (rem_sh >= {1'b0, den_in});
    rem_n  = ge ? DEN_W'(rem_sh - {1'b0, den_in}) : rem_sh[DEN_W-1:0];
    acc_n  = {acc_in[NUM_W-2:0], ge};
    quo_t  = acc_q[QUO_W-1:0];
    quo    = neg_q ? -quo_t : quo_t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      den_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_n;
        acc_q <= acc_n;
        den_q <= den;
        neg_q <= num[NUM_W-1];
        cnt_q <= CW'(NUM_W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_n;
        acc_q <= acc_n;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aud_dsp_pm.sv
// Playback engine: reads PCM from SRAM once per DAC frame with fast/slow/reverse
// speed modes and optional linear interpolation between neighbouring samples.
//
// state     | meaning
// IDLE      | stopped, output forced to zero
// WAIT_LRCK | waiting for the next DAC frame rising edge
// FETCH0    | SRAM address = cursor, s0 captured at end of cycle
// FETCH1    | SRAM address = neighbour, s1 captured at end of cycle
// CALC      | produce sample (direct or via divider), then advance cursor
// PAUSE     | halted with cursor and sub-step retained, output zero
module aud_dsp_pm
  import aud_pkg::*;
#(
  parameter int DATA_W  = AUD_DATA_W,
  parameter int ADDR_W  = AUD_ADDR_W,
  parameter int SPEED_W = AUD_SPEED_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_pause,
  input  logic                     i_stop,
  input  logic                     i_fast,
  input  logic                     i_interp,
  input  logic                     i_reverse,
  input  logic [SPEED_W-1:0]       i_speed,
  input  logic [ADDR_W-1:0]        i_end_addr,
  input  logic                     i_daclrck,
  output logic [ADDR_W-1:0]        o_sram_addr,
  input  logic signed [DATA_W-1:0] i_sram_data,
  output logic signed [DATA_W-1:0] o_dac_data,
  output logic                     o_dac_valid,
  output logic                     o_done,
  output logic [2:0]               o_state
);

  localparam int NUM_W = DATA_W + SPEED_W + 1;
  localparam int NW    = SPEED_W + 1;
  localparam int AW1   = ADDR_W + 1;

  state_t                    state;
  logic [ADDR_W-1:0]         cursor, next_cursor, nb_addr;
  logic [SPEED_W-1:0]        k, k_next, speed_l;
  logic                      fast_l, interp_l, rev_l;
  logic                      pause_pend, lrck_q, div_launched, end_pend;
  logic signed [DATA_W-1:0]  s0, s1, out_val;

  logic [NW-1:0]             n_val, n_minus_k;
  logic [AW1-1:0]            step, fwd_sum, rev_diff;
  logic                      wrap, use_div, at_end, nb_oob, lrck_rise;
  logic                      div_start, div_busy, div_done, out_now;
  logic signed [NUM_W-1:0]   s0_x, s1_x, w0_x, w1_x, num;
  logic signed [DATA_W-1:0]  div_quo;

  always_comb begin
    n_val     = {1'b0, speed_l} + NW'(1);
    wrap      = (k == speed_l);
    n_minus_k = n_val - {1'b0, k};
    use_div   = interp_l && !fast_l && (speed_l != '0);
    step      = fast_l ? AW1'(n_val) : (wrap ? AW1'(1) : '0);
    // The extra top bit is the carry (forward) or borrow (reverse) past the track.
    fwd_sum     = {1'b0, cursor} + step;
    rev_diff    = {1'b0, cursor} - step;
    at_end      = rev_l ? rev_diff[ADDR_W] : (fwd_sum > {1'b0, i_end_addr});
    next_cursor = rev_l ? rev_diff[ADDR_W-1:0] : fwd_sum[ADDR_W-1:0];
    k_next      = (fast_l || wrap) ? '0 : k + 1'b1;
    nb_oob      = rev_l ? (cursor == '0) : (cursor >= i_end_addr);
    nb_addr     = rev_l ? cursor - 1'b1 : cursor + 1'b1;
    s0_x        = NUM_W'(s0);
    s1_x        = NUM_W'(s1);
    w0_x        = NUM_W'(n_minus_k);
    w1_x        = NUM_W'(k);
    num         = s0_x * w0_x + s1_x * w1_x;
    lrck_rise   = i_daclrck && !lrck_q;
    div_start   = (state == ST_CALC) && use_div && !div_launched && !div_busy && !end_pend;
    out_now     = (state == ST_CALC) && !end_pend && (use_div ? div_done : 1'b1);
    out_val     = use_div ? div_quo : s0;
  end

  aud_div_seq #(
    .NUM_W (NUM_W),
    .DEN_W (NW),
    .QUO_W (DATA_W)
  ) u_div (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (div_start),
    .abort (i_stop),
    .num   (num),
    .den   (n_val),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cursor       <= '0;
      k            <= '0;
      speed_l      <= '0;
      fast_l       <= 1'b0;
      interp_l     <= 1'b0;
      rev_l        <= 1'b0;
      pause_pend   <= 1'b0;
      lrck_q       <= 1'b0;
      div_launched <= 1'b0;
      end_pend     <= 1'b0;
      s0           <= '0;
      s1           <= '0;
      o_sram_addr  <= '0;
      o_dac_data   <= '0;
      o_dac_valid  <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      lrck_q      <= i_daclrck;
      o_dac_valid <= 1'b0;
      o_done      <= 1'b0;
      if (i_stop) begin
        state        <= ST_IDLE;
        cursor       <= '0;
        k            <= '0;
        pause_pend   <= 1'b0;
        div_launched <= 1'b0;
        end_pend     <= 1'b0;
        o_sram_addr  <= '0;
        o_dac_data   <= '0;
      end else begin
        if (i_pause && (state inside {ST_WAIT_LRCK, ST_FETCH0, ST_FETCH1, ST_CALC}))
          pause_pend <= 1'b1;
        case (state)
          ST_IDLE: begin
            o_dac_data <= '0;
            if (i_start) begin
              cursor     <= i_reverse ? i_end_addr : '0;
              k          <= '0;
              pause_pend <= 1'b0;
              state      <= ST_WAIT_LRCK;
            end
          end
          ST_WAIT_LRCK: begin
            if (pause_pend) begin
              pause_pend <= 1'b0;
              o_dac_data <= '0;
              state      <= ST_PAUSE;
            end else if (lrck_rise) begin
              fast_l      <= i_fast;
              interp_l    <= i_interp;
              rev_l       <= i_reverse;
              speed_l     <= i_speed;
              o_sram_addr <= cursor;
              state       <= ST_FETCH0;
            end
          end
          ST_FETCH0: begin
            s0           <= i_sram_data;
            div_launched <= 1'b0;
            end_pend     <= 1'b0;
            if (use_div) begin
              o_sram_addr <= nb_addr;
              state       <= ST_FETCH1;
            end else begin
              state <= ST_CALC;
            end
          end
          ST_FETCH1: begin
            s1    <= nb_oob ? s0 : i_sram_data;
            state <= ST_CALC;
          end
          ST_CALC: begin
            if (div_start)
              div_launched <= 1'b1;
            // End of track: the last sample goes out first, o_done one cycle later.
            if (end_pend) begin
              o_done     <= 1'b1;
              o_dac_data <= '0;
              pause_pend <= 1'b0;
              end_pend   <= 1'b0;
              state      <= ST_IDLE;
            end else if (out_now) begin
              o_dac_data  <= out_val;
              o_dac_valid <= 1'b1;
              if (at_end) begin
                end_pend <= 1'b1;
              end else begin
                cursor <= next_cursor;
                k      <= k_next;
                state  <= ST_WAIT_LRCK;
              end
            end
          end
          ST_PAUSE: begin
            o_dac_data <= '0;
            if (i_start)
              state <= ST_WAIT_LRCK;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_aud_dsp_pm.sv
// Directed bench for aud_dsp_pm: fast/slow/interp/reverse playback, pause/resume,
// stop and reset aborts, with a small behavioural SRAM.
module tb_aud_dsp_pm;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic               fast = 1'b0, interp = 1'b0, reverse = 1'b0, daclrck = 1'b0;
  logic [2:0]         speed = 3'd0;
  logic [19:0]        end_addr = 20'd0;
  logic [19:0]        sram_addr;
  logic signed [15:0] sram_data, dac_data;
  logic               dac_valid, done;
  logic [2:0]         state;

  logic signed [15:0] mem [0:15];
  int checks = 0;
  int errors = 0;

  logic signed [15:0] v;
  logic [19:0]        a;
  bit                 ok, dn;

  always #5 clk = ~clk;

  assign sram_data = (sram_addr < 20'd16) ? mem[sram_addr[3:0]] : 16'sd0;

  aud_dsp_pm dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_fast      (fast),
    .i_interp    (interp),
    .i_reverse   (reverse),
    .i_speed     (speed),
    .i_end_addr  (end_addr),
    .i_daclrck   (daclrck),
    .o_sram_addr (sram_addr),
    .i_sram_data (sram_data),
    .o_dac_data  (dac_data),
    .o_dac_valid (dac_valid),
    .o_done      (done),
    .o_state     (state)
  );

  task automatic cmd(input logic s, input logic p, input logic t);
    @(negedge clk);
    start = s; pause = p; stop = t;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic setup(input logic f, input logic i, input logic r, input logic [2:0] sp,
                       input logic [19:0] e);
    fast = f; interp = i; reverse = r; speed = sp; end_addr = e;
  endtask

  // One DAC frame: rising edge, wait (bounded) for the sample, then sample o_done.
  task automatic frame(output logic signed [15:0] fv, output logic [19:0] fa,
                       output bit fok, output bit fdn);
    fok = 1'b0; fdn = 1'b0; fv = '0; fa = '0;
    @(negedge clk);
    daclrck = 1'b1;
    for (int i = 0; i < 40 && !fok; i++) begin
      @(negedge clk);
      if (dac_valid) begin
        fok = 1'b1;
        fv  = dac_data;
        fa  = sram_addr;
      end
    end
    daclrck = 1'b0;
    @(negedge clk);
    fdn = done;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd0 || dac_data !== 16'sd0 || dac_valid !== 1'b0 || done !== 1'b0 ||
        sram_addr !== 20'd0) begin
      errors++;
      $display("FAIL reset state=%0d data=%0d valid=%0b done=%0b addr=%0d want all 0",
               state, dac_data, dac_valid, done, sram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fast();
    logic signed [15:0] exp_v [5] = '{16'sd0, 16'sd8, 16'sd16, 16'sd24, 16'sd32};
    for (int i = 0; i < 16; i++) mem[i] = 16'(4 * i);
    setup(1'b1, 1'b0, 1'b0, 3'd1, 20'd9);
    cmd(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      frame(v, a, ok, dn);
      checks++;
      if (!ok || v !== exp_v[n]) begin
        errors++;
        $display("FAIL fast_s%0d got %0d (valid=%0b) want %0d", n, v, ok, exp_v[n]);
      end
      checks++;
      if (dn !== (n == 4)) begin
        errors++;
        $display("FAIL fast_done%0d got %0b want %0b", n, dn, (n == 4));
      end
    end
    checks++;
    if (state !== 3'd0 || dac_data !== 16'sd0) begin
      errors++;
      $display("FAIL fast_end state=%0d data=%0d want 0 0", state, dac_data);
    end
  endtask

  task automatic test_interp();
    logic signed [15:0] exp_v [5] = '{16'sd100, 16'sd125, 16'sd150, 16'sd175, 16'sd200};
    mem[0] = 16'sd100; mem[1] = 16'sd200; mem[2] = 16'sd300;
    setup(1'b0, 1'b1, 1'b0, 3'd3, 20'd9);
    cmd(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      frame(v, a, ok, dn);
      checks++;
      if (!ok || v !== exp_v[n]) begin
        errors++;
        $display("FAIL interp_s%0d got %0d (valid=%0b) want %0d", n, v, ok, exp_v[n]);
      end
    end
    cmd(1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL interp_stop state=%0d want 0", state);
    end
  endtask

  task automatic test_trunc();
    mem[0] = -16'sd7; mem[1] = 16'sd0;
    setup(1'b0, 1'b1, 1'b0, 3'd1, 20'd9);
    cmd(1'b1, 1'b0, 1'b0);
    frame(v, a, ok, dn);
    checks++;
    if (!ok || v !== -16'sd7) begin
      errors++;
      $display("FAIL trunc_k0 got %0d (valid=%0b) want -7", v, ok);
    end
    frame(v, a, ok, dn);
    checks++;
    if (!ok || v !== -16'sd3) begin
      errors++;
      $display("FAIL trunc_k1 got %0d (valid=%0b) want -3", v, ok);
    end
    cmd(1'b0, 1'b0, 1'b1);
  endtask

  // Neighbour beyond end_addr falls back to s0, so interpolation stays flat.
  task automatic test_interp_edge();
    mem[0] = -16'sd7; mem[1] = 16'sd0;
    setup(1'b0, 1'b1, 1'b0, 3'd1, 20'd0);
    cmd(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      frame(v, a, ok, dn);
      checks++;
      if (!ok || v !== -16'sd7 || dn !== (n == 1)) begin
        errors++;
        $display("FAIL edge_s%0d got %0d done=%0b want -7 done=%0b", n, v, dn, (n == 1));
      end
    end
  endtask

  task automatic test_reverse();
    logic signed [15:0] exp_v [6] = '{16'sd33, 16'sd33, 16'sd22, 16'sd22, 16'sd11, 16'sd11};
    logic [19:0]        exp_a [6] = '{20'd2, 20'd2, 20'd1, 20'd1, 20'd0, 20'd0};
    mem[0] = 16'sd11; mem[1] = 16'sd22; mem[2] = 16'sd33;
    setup(1'b0, 1'b0, 1'b1, 3'd1, 20'd2);
    cmd(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      frame(v, a, ok, dn);
      checks++;
      if (!ok || v !== exp_v[n] || a !== exp_a[n]) begin
        errors++;
        $display("FAIL rev_s%0d got %0d addr %0d want %0d addr %0d", n, v, a, exp_v[n], exp_a[n]);
      end
      checks++;
      if (dn !== (n == 5)) begin
        errors++;
        $display("FAIL rev_done%0d got %0b want %0b", n, dn, (n == 5));
      end
    end
    checks++;
    if (state !== 3'd0 || sram_addr !== 20'd0) begin
      errors++;
      $display("FAIL rev_end state=%0d addr=%0d want 0 0", state, sram_addr);
    end
  endtask

  task automatic test_pause();
    logic signed [15:0] exp_v [5] = '{16'sd0, 16'sd0, 16'sd4, 16'sd4, 16'sd8};
    int vcount;
    for (int i = 0; i < 16; i++) mem[i] = 16'(4 * i);
    setup(1'b0, 1'b0, 1'b0, 3'd1, 20'd20);
    cmd(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      if (n == 3) begin
        cmd(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd5 || dac_data !== 16'sd0) begin
          errors++;
          $display("FAIL pause_enter state=%0d data=%0d want 5 0", state, dac_data);
        end
        vcount = 0;
        for (int f = 0; f < 10; f++) begin
          daclrck = 1'b1;
          repeat (5) begin @(negedge clk); if (dac_valid || dac_data !== 16'sd0) vcount++; end
          daclrck = 1'b0;
          repeat (5) begin @(negedge clk); if (dac_valid || dac_data !== 16'sd0) vcount++; end
        end
        checks++;
        if (vcount !== 0 || state !== 3'd5) begin
          errors++;
          $display("FAIL pause_hold activity=%0d state=%0d want 0 5", vcount, state);
        end
        cmd(1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 3'd1) begin
          errors++;
          $display("FAIL pause_resume state=%0d want 1", state);
        end
      end
      frame(v, a, ok, dn);
      checks++;
      if (!ok || v !== exp_v[n]) begin
        errors++;
        $display("FAIL pause_s%0d got %0d (valid=%0b) want %0d", n, v, ok, exp_v[n]);
      end
    end
    cmd(1'b0, 1'b0, 1'b1);
  endtask

  task automatic enter_calc(output bit reached);
    reached = 1'b0;
    @(negedge clk);
    daclrck = 1'b1;
    for (int i = 0; i < 10 && !reached; i++) begin
      @(negedge clk);
      if (state == 3'd4) reached = 1'b1;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stop_calc();
    int act;
    bit reached;
    mem[0] = 16'sd100; mem[1] = 16'sd200;
    setup(1'b0, 1'b1, 1'b0, 3'd3, 20'd9);
    cmd(1'b1, 1'b0, 1'b0);
    frame(v, a, ok, dn);
    checks++;
    if (!ok || v !== 16'sd100) begin
      errors++;
      $display("FAIL stop_pre got %0d want 100", v);
    end
    enter_calc(reached);
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL stop_calc_reach state=%0d want 4", state);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; daclrck = 1'b0;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      if (dac_valid || done || state !== 3'd0 || dac_data !== 16'sd0) act++;
      @(negedge clk);
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL stop_calc activity=%0d state=%0d data=%0d want 0 0 0", act, state, dac_data);
    end
  endtask

  task automatic test_reset_div();
    int act;
    bit reached;
    cmd(1'b1, 1'b0, 1'b0);
    frame(v, a, ok, dn);
    enter_calc(reached);
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL rst_calc_reach state=%0d want 4", state);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || dac_data !== 16'sd0 || sram_addr !== 20'd0 || dac_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_div state=%0d data=%0d addr=%0d want 0 0 0", state, dac_data, sram_addr);
    end
    rst = 1'b0; daclrck = 1'b0;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dac_valid || done || state !== 3'd0) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL rst_div_after activity=%0d want 0", act);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_fast();
    test_interp();
    test_trunc();
    test_interp_edge();
    test_reverse();
    test_pause();
    test_stop_calc();
    test_reset_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
